// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} arb_state_t;
    typedef enum logic {GNT_CPU, GNT_HOST} gnt_t;

    localparam int RD_LAT_MAX = 7;
    localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with a last-grant register
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_cpu_i,
    input  logic req_host_i,
    input  logic update_i,
    input  gnt_t upd_gnt_i,
    output logic gnt_valid_o,
    output gnt_t gnt_o
);

    gnt_t last_q;

    // Resetting to HOST lets the cpu win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_HOST;
        end else if (update_i) begin
            last_q <= upd_gnt_i;
        end
    end

    always_comb begin
        gnt_valid_o = req_cpu_i | req_host_i;
        if (req_cpu_i && req_host_i) begin
            gnt_o = (last_q == GNT_CPU) ? GNT_HOST : GNT_CPU;
        end else if (req_host_i) begin
            gnt_o = GNT_HOST;
        end else begin
            gnt_o = GNT_CPU;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one single-port data RAM between the cpu and a host port
module dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t        state_q, state_d;
    gnt_t              gnt_q, gnt_d, arb_gnt;
    logic              arb_valid;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              rr_update;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst_n       (rst),
        .req_cpu_i   (cpu_req),
        .req_host_i  (host_req),
        .update_i    (rr_update),
        .upd_gnt_i   (gnt_q),
        .gnt_valid_o (arb_valid),
        .gnt_o       (arb_gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            gnt_q        <= GNT_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // Request fields are captured only in IDLE; later changes on the ports are ignored.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d = arb_gnt;
                    if (arb_gnt == GNT_CPU) begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end else begin
                        we_d    = host_we;
                        addr_d  = host_addr;
                        wdata_d = host_wdata;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (gnt_q == GNT_CPU) begin
                        cpu_rdata_d = mem_rdata;
                    end else begin
                        host_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A write completes in ACCESS, a read in DONE; both close the round-robin turn.
    always_comb begin
        mem_en    = (state_q == ACCESS);
        mem_we    = (state_q == ACCESS) && we_q;
        rr_update = ((state_q == ACCESS) && we_q) || (state_q == DONE);
        cpu_ack   = rr_update && (gnt_q == GNT_CPU);
        host_ack  = rr_update && (gnt_q == GNT_HOST);
        busy      = (state_q != IDLE);
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;
    assign cpu_stall  = cpu_req & ~cpu_ack;

endmodule
